llc_snoop_responder: RTL and testbench

Snoop-side responder of the last-level cache: accepts bus operations snooped from other caches (READ, WRITE, INVALIDATE, RWIM), looks the line up in the 16-way tag/MESI array, and returns NOHIT/HIT/HITM. It sequences the required L1 messages (GETLINE, INVALIDATELINE), the modified-line writeback, and the MESI update. It sits between the bus snoop port and the tag/MESI array, as the counterpart of the LLC's own bus-request path.

---
 rtl/llc_snoop_responder.sv | 259 +++++++++++++++++++++++++
 tb/tb_llc_snoop_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : llc_snoop_responder
// Purpose  : LLC snoop responder; tag/MESI lookup, L1 messaging, writeback and
//            MESI update. Optional statistics counters under SNOOP_STATS_EN.
// Revision : 1.0
// ============================================================================
module llc_snoop_responder #(
    parameter int ADDR_W = 32,
    parameter int WAYS   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      snp_valid,
    output logic                      snp_ready,
    input  logic [1:0]                snp_op,
    input  logic [ADDR_W-1:0]         snp_addr,
    output logic                      res_valid,
    output logic [1:0]                res,
    output logic                      arr_rd_en,
    output logic [13:0]               arr_index,
    input  logic [WAYS*12-1:0]        arr_tags,
    input  logic [WAYS*2-1:0]         arr_mesi,
    output logic                      arr_wr_en,
    output logic [$clog2(WAYS)-1:0]   arr_wr_way,
    output logic [1:0]                arr_wr_mesi,
    output logic                      l1_valid,
    input  logic                      l1_ready,
    output logic [1:0]                l1_msg,
    output logic [ADDR_W-1:0]         l1_addr,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic                      proto_err,
    output logic [31:0]               cnt_hit,
    output logic [31:0]               cnt_hitm,
    output logic [31:0]               cnt_nohit
);
    localparam int TAG_W  = 12;
    localparam int IDX_W  = 14;
    localparam int OFF_W  = 6;
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int WAY_W  = $clog2(WAYS);

    localparam logic [1:0] c_OP_READ  = 2'd0;
    localparam logic [1:0] c_OP_INVAL = 2'd2;
    localparam logic [1:0] c_OP_RWIM  = 2'd3;
    localparam logic [1:0] c_NOHIT    = 2'd0;
    localparam logic [1:0] c_HIT      = 2'd1;
    localparam logic [1:0] c_HITM     = 2'd2;
    localparam logic [1:0] c_MESI_M   = 2'd0;
    localparam logic [1:0] c_MESI_E   = 2'd1;
    localparam logic [1:0] c_MESI_S   = 2'd2;
    localparam logic [1:0] c_MESI_I   = 2'd3;
    localparam logic [1:0] c_GETLINE  = 2'd0;
    localparam logic [1:0] c_INVLINE  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_RD = 3'd1, S_CMP = 3'd2, S_GET = 3'd3,
        S_WB = 3'd4, S_INV = 3'd5, S_UPD = 3'd6
    } state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [LINE_W-1:0]  r_line;
    logic [WAY_W-1:0]   r_way;
    logic [1:0]         r_new_mesi;
    logic               r_snp_ready, r_arr_rd_en, r_arr_wr_en;
    logic               r_l1_valid, r_wb_valid, r_proto_err;
    logic [1:0]         r_l1_msg;

    logic [WAYS-1:0]    w_match;
    logic [WAY_W-1:0]   w_hit_way;
    logic               w_hit, w_multi, w_err;
    logic [1:0]         w_hit_mesi, w_res, w_new_mesi;
    state_t             w_next;
    logic               w_unused_offset;

    assign w_unused_offset = ^snp_addr[OFF_W-1:0];

    for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
        assign w_match[gw] = (arr_tags[gw*TAG_W +: TAG_W] == r_line[LINE_W-1 -: TAG_W])
                             && (arr_mesi[gw*2 +: 2] != c_MESI_I);
    end

    always_comb begin
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_match[w]) w_hit_way = WAY_W'(w);
        end
    end

    assign w_hit      = |w_match;
    assign w_multi    = |(w_match & (w_match - WAYS'(1)));
    assign w_hit_mesi = arr_mesi[w_hit_way*2 +: 2];

    // Snoop response and follow-up path, evaluated while the array data is valid.
    always_comb begin
        w_res      = c_NOHIT;
        w_next     = S_IDLE;
        w_new_mesi = c_MESI_I;
        w_err      = w_multi;
        if (w_hit) begin
            case (r_op)
                c_OP_READ: begin
                    w_new_mesi = c_MESI_S;
                    if (w_hit_mesi == c_MESI_M) begin
                        w_res  = c_HITM;
                        w_next = S_GET;
                    end else if (w_hit_mesi == c_MESI_E) begin
                        w_res  = c_HIT;
                        w_next = S_UPD;
                    end else begin
                        w_res  = c_HIT;
                    end
                end
                c_OP_RWIM: begin
                    w_res  = (w_hit_mesi == c_MESI_M) ? c_HITM : c_HIT;
                    w_next = (w_hit_mesi == c_MESI_M) ? S_GET : S_INV;
                end
                c_OP_INVAL: begin
                    if (w_hit_mesi == c_MESI_S) begin
                        w_res  = c_HIT;
                        w_next = S_INV;
                    end else begin
                        w_err  = 1'b1;
                    end
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_line      <= '0;
            r_way       <= '0;
            r_new_mesi  <= '0;
            r_snp_ready <= 1'b1;
            r_arr_rd_en <= 1'b0;
            r_arr_wr_en <= 1'b0;
            r_l1_valid  <= 1'b0;
            r_l1_msg    <= '0;
            r_wb_valid  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_arr_rd_en <= 1'b0;
            r_arr_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (snp_valid) begin
                        r_op        <= snp_op;
                        r_line      <= snp_addr[ADDR_W-1:OFF_W];
                        r_snp_ready <= 1'b0;
                        r_arr_rd_en <= 1'b1;
                        r_state     <= S_RD;
                    end
                end
                S_RD: r_state <= S_CMP;
                S_CMP: begin
                    r_way      <= w_hit_way;
                    r_new_mesi <= w_new_mesi;
                    r_state    <= w_next;
                    if (w_err) r_proto_err <= 1'b1;
                    case (w_next)
                        S_GET: begin
                            r_l1_valid <= 1'b1;
                            r_l1_msg   <= c_GETLINE;
                        end
                        S_INV: begin
                            r_l1_valid <= 1'b1;
                            r_l1_msg   <= c_INVLINE;
                        end
                        S_UPD:   r_arr_wr_en <= 1'b1;
                        default: r_snp_ready <= 1'b1;
                    endcase
                end
                S_GET: begin
                    if (l1_ready) begin
                        r_l1_valid <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_state    <= S_WB;
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        r_wb_valid <= 1'b0;
                        if (r_op == c_OP_RWIM) begin
                            r_l1_valid <= 1'b1;
                            r_l1_msg   <= c_INVLINE;
                            r_state    <= S_INV;
                        end else begin
                            r_arr_wr_en <= 1'b1;
                            r_state     <= S_UPD;
                        end
                    end
                end
                S_INV: begin
                    if (l1_ready) begin
                        r_l1_valid  <= 1'b0;
                        r_arr_wr_en <= 1'b1;
                        r_state     <= S_UPD;
                    end
                end
                S_UPD: begin
                    r_snp_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_snp_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign snp_ready   = r_snp_ready;
    assign res_valid   = (r_state == S_CMP);
    assign res         = res_valid ? w_res : c_NOHIT;
    assign arr_rd_en   = r_arr_rd_en;
    assign arr_index   = r_line[IDX_W-1:0];
    assign arr_wr_en   = r_arr_wr_en;
    assign arr_wr_way  = r_way;
    assign arr_wr_mesi = r_new_mesi;
    assign l1_valid    = r_l1_valid;
    assign l1_msg      = r_l1_msg;
    assign l1_addr     = {r_line, {OFF_W{1'b0}}};
    assign wb_valid    = r_wb_valid;
    assign wb_addr     = {r_line, {OFF_W{1'b0}}};
    assign proto_err   = r_proto_err;

`ifdef SNOOP_STATS_EN
    logic [31:0] r_cnt_hit, r_cnt_hitm, r_cnt_nohit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_hit   <= '0;
            r_cnt_hitm  <= '0;
            r_cnt_nohit <= '0;
        end else if (res_valid) begin
            if (res == c_HIT && r_cnt_hit != 32'hFFFF_FFFF)     r_cnt_hit   <= r_cnt_hit + 32'd1;
            if (res == c_HITM && r_cnt_hitm != 32'hFFFF_FFFF)   r_cnt_hitm  <= r_cnt_hitm + 32'd1;
            if (res == c_NOHIT && r_cnt_nohit != 32'hFFFF_FFFF) r_cnt_nohit <= r_cnt_nohit + 32'd1;
        end
    end

    assign cnt_hit   = r_cnt_hit;
    assign cnt_hitm  = r_cnt_hitm;
    assign cnt_nohit = r_cnt_nohit;
`else
    assign cnt_hit   = '0;
    assign cnt_hitm  = '0;
    assign cnt_nohit = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_llc_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_llc_snoop_responder
// Purpose  : Table vectors, reset-abort sequence and randomized snoops against
//            a rule-level model of the snoop responder.
// Revision : 1.0
// ============================================================================
module tb_llc_snoop_responder;
    localparam int WAYS = 16;
    localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_INV = 2'd2, OP_RWIM = 2'd3;
    localparam logic [1:0] R_NOHIT = 2'd0, R_HIT = 2'd1, R_HITM = 2'd2;
    localparam logic [1:0] MM = 2'd0, ME = 2'd1, MS = 2'd2, MI = 2'd3;
    localparam logic [1:0] L_GET = 2'd0, L_INV = 2'd2;
`ifdef SNOOP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic snp_valid = 1'b0, snp_ready;
    logic [1:0] snp_op = '0;
    logic [31:0] snp_addr = '0;
    logic res_valid;
    logic [1:0] res;
    logic arr_rd_en, arr_wr_en;
    logic [13:0] arr_index;
    logic [WAYS*12-1:0] arr_tags = '0;
    logic [WAYS*2-1:0] arr_mesi = '1;
    logic [3:0] arr_wr_way;
    logic [1:0] arr_wr_mesi, l1_msg;
    logic l1_valid, wb_valid, proto_err;
    logic l1_ready = 1'b0, wb_ready = 1'b0;
    logic [31:0] l1_addr, wb_addr, cnt_hit, cnt_hitm, cnt_nohit;

    always #5 clk = ~clk;

    llc_snoop_responder #(.ADDR_W(32), .WAYS(WAYS)) dut (
        .clk(clk), .rst(rst),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
        .res_valid(res_valid), .res(res),
        .arr_rd_en(arr_rd_en), .arr_index(arr_index), .arr_tags(arr_tags), .arr_mesi(arr_mesi),
        .arr_wr_en(arr_wr_en), .arr_wr_way(arr_wr_way), .arr_wr_mesi(arr_wr_mesi),
        .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_msg(l1_msg), .l1_addr(l1_addr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .proto_err(proto_err), .cnt_hit(cnt_hit), .cnt_hitm(cnt_hitm), .cnt_nohit(cnt_nohit)
    );

    typedef struct {
        logic [1:0] res;
        bit get, wb, inv, wr;
        logic [1:0] nm;
        int way;
        bit err;
        int ready;
    } exp_t;

    typedef struct {
        logic [1:0] op;
        int hway;
        logic [1:0] st;
        int l1w, wbw;
        exp_t e;
    } vec_t;

    logic [11:0] set_tag [WAYS];
    logic [1:0]  set_st  [WAYS];
    int n_checks = 0, n_pass = 0;
    int exp_hit = 0, exp_hitm = 0, exp_nohit = 0;
    bit exp_err = 1'b0;

    int ob_rd_cycle, ob_res_cycle, ob_res_cnt, ob_ready_cycle, ob_wb_cnt, ob_wr_cnt, ob_nl1;
    logic [13:0] ob_rd_idx;
    logic [1:0] ob_res, ob_wr_mesi;
    logic [3:0] ob_wr_way, ob_l1seq;
    bit ob_bad, ob_start_rdy;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic load_set();
        for (int w = 0; w < WAYS; w++) begin
            arr_tags[w*12 +: 12] = set_tag[w];
            arr_mesi[w*2 +: 2]   = set_st[w];
        end
    endtask

    // hway < 0: every way carries the tag but is Invalid.
    task automatic build_set(input logic [11:0] tag, input int hway, input logic [1:0] st);
        for (int w = 0; w < WAYS; w++) begin
            set_tag[w] = (hway < 0) ? tag : (tag ^ 12'(w + 1));
            set_st[w]  = (hway < 0) ? MI : 2'($urandom);
        end
        if (hway >= 0) begin
            set_tag[hway] = tag;
            set_st[hway]  = st;
        end
    endtask

    // Response rules expressed per (op, state of lowest valid matching way).
    function automatic exp_t model(input logic [1:0] op, input logic [11:0] tag, input int l1w, input int wbw);
        exp_t e;
        int hits[$];
        logic [1:0] s;
        e = '{res: R_NOHIT, get: 0, wb: 0, inv: 0, wr: 0, nm: MI, way: 0, err: 0, ready: 3};
        for (int w = 0; w < WAYS; w++)
            if (set_tag[w] == tag && set_st[w] != MI) hits.push_back(w);
        e.err = (hits.size() > 1);
        if (hits.size() > 0) begin
            e.way = hits[0];
            s = set_st[hits[0]];
            case (op)
                OP_READ: begin
                    e.res = (s == MM) ? R_HITM : R_HIT;
                    e.get = (s == MM); e.wb = (s == MM); e.wr = (s != MS); e.nm = MS;
                end
                OP_RWIM: begin
                    e.res = (s == MM) ? R_HITM : R_HIT;
                    e.get = (s == MM); e.wb = (s == MM); e.inv = 1; e.wr = 1; e.nm = MI;
                end
                OP_INV: begin
                    if (s == MS) begin e.res = R_HIT; e.inv = 1; e.wr = 1; end
                    else e.err = 1;
                end
                default: e.err = 1;
            endcase
        end
        e.ready = 3 + (e.get ? 1 + l1w : 0) + (e.wb ? 1 + wbw : 0) + (e.inv ? 1 + l1w : 0) + (e.wr ? 1 : 0);
        return e;
    endfunction

    task automatic run_snoop(input logic [1:0] op, input logic [31:0] addr, input int l1w, input int wbw);
        int c = 0, l1h = 0, wbh = 0;
        bit done = 0;
        logic [1:0] l1m_prev = '0;
        logic [31:0] line = {addr[31:6], 6'd0};
        ob_rd_cycle = -1; ob_res_cycle = -1; ob_res_cnt = 0; ob_ready_cycle = -1;
        ob_wb_cnt = 0; ob_wr_cnt = 0; ob_nl1 = 0; ob_l1seq = '0; ob_bad = 0;
        ob_rd_idx = '0; ob_res = '0; ob_wr_mesi = '0; ob_wr_way = '0; ob_start_rdy = 0;
        load_set();
        while (!done && c < 64) begin
            @(negedge clk);
            if (c == 0) begin
                ob_start_rdy = snp_ready;
                snp_valid = 1; snp_op = op; snp_addr = addr;
            end else begin
                snp_valid = (c < 3);
                snp_op = ~op; snp_addr = ~addr;
            end
            if (arr_rd_en) begin ob_rd_cycle = c; ob_rd_idx = arr_index; end
            if (res_valid) begin ob_res_cnt++; ob_res_cycle = c; ob_res = res; end
            if (l1_valid) begin
                if (l1h == 0) begin
                    ob_l1seq = {ob_l1seq[1:0], l1_msg}; ob_nl1++; l1m_prev = l1_msg;
                end else if (l1_msg != l1m_prev) ob_bad = 1;
                if (l1_addr != line) ob_bad = 1;
                l1_ready = (l1h >= l1w);
                l1h = l1_ready ? 0 : l1h + 1;
            end else l1_ready = 0;
            if (wb_valid) begin
                if (wbh == 0) ob_wb_cnt++;
                if (wb_addr != line) ob_bad = 1;
                wb_ready = (wbh >= wbw);
                wbh = wb_ready ? 0 : wbh + 1;
            end else wb_ready = 0;
            if (arr_wr_en) begin ob_wr_cnt++; ob_wr_way = arr_wr_way; ob_wr_mesi = arr_wr_mesi; end
            if (c > 0 && snp_ready) begin ob_ready_cycle = c; done = 1; end
            c++;
        end
        snp_valid = 0; l1_ready = 0; wb_ready = 0;
    endtask

    task automatic compare(input string nm, input exp_t e, input logic [31:0] addr);
        logic [3:0] seq = '0;
        int n = 0;
        if (e.get) begin seq = {seq[1:0], L_GET}; n++; end
        if (e.inv) begin seq = {seq[1:0], L_INV}; n++; end
        exp_err = exp_err | e.err;
        if (e.res == R_HIT) exp_hit++;
        else if (e.res == R_HITM) exp_hitm++;
        else exp_nohit++;
        check({nm, " start_ready"}, ob_start_rdy, 1);
        check({nm, " rd"}, {ob_rd_cycle, ob_rd_idx}, {32'd1, addr[19:6]});
        check({nm, " res_time"}, {ob_res_cnt, ob_res_cycle}, {32'd1, 32'd2});
        check({nm, " res"}, ob_res, e.res);
        check({nm, " l1"}, {ob_nl1, ob_l1seq, ob_bad}, {n, seq, 1'b0});
        check({nm, " wb"}, ob_wb_cnt, e.wb);
        if (e.wr) check({nm, " wr"}, {ob_wr_cnt, ob_wr_way, ob_wr_mesi}, {32'd1, 4'(e.way), e.nm});
        else      check({nm, " nowr"}, ob_wr_cnt, 0);
        check({nm, " proto_err"}, proto_err, exp_err);
        check({nm, " ready_cycle"}, ob_ready_cycle, e.ready);
        check({nm, " counters"}, {cnt_hit, cnt_hitm, cnt_nohit},
              STATS ? {exp_hit, exp_hitm, exp_nohit} : 96'd0);
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        exp_err = 0; exp_hit = 0; exp_hitm = 0; exp_nohit = 0;
        @(negedge clk);
        check("reset ready", snp_ready, 1);
        check("reset outputs", {res_valid, res, arr_rd_en, arr_wr_en, l1_valid, wb_valid, proto_err}, 0);
        check("reset counters", {cnt_hit, cnt_hitm, cnt_nohit}, 0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic [31:0] a = $urandom;
        build_set(a[31:20], v.hway, v.st);
        v.e.way = (v.hway < 0) ? 0 : v.hway;
        run_snoop(v.op, a, v.l1w, v.wbw);
        compare(nm, v.e, a);
    endtask

    vec_t tbl [13];

    initial begin
        // op, way, state, l1 wait, wb wait, {res, get, wb, inv, wr, new, way, err, ready}
        tbl[0]  = '{OP_READ,  5, MM, 0, 0, '{R_HITM,  1, 1, 0, 1, MS, 0, 0, 6}};
        tbl[1]  = '{OP_READ,  3, ME, 0, 0, '{R_HIT,   0, 0, 0, 1, MS, 0, 0, 4}};
        tbl[2]  = '{OP_READ,  2, MS, 1, 1, '{R_HIT,   0, 0, 0, 0, MS, 0, 0, 3}};
        tbl[3]  = '{OP_READ, -1, MI, 0, 0, '{R_NOHIT, 0, 0, 0, 0, MI, 0, 0, 3}};
        tbl[4]  = '{OP_RWIM,  0, MS, 3, 0, '{R_HIT,   0, 0, 1, 1, MI, 0, 0, 8}};
        tbl[5]  = '{OP_RWIM,  7, MM, 1, 2, '{R_HITM,  1, 1, 1, 1, MI, 0, 0, 11}};
        tbl[6]  = '{OP_RWIM, 15, ME, 0, 0, '{R_HIT,   0, 0, 1, 1, MI, 0, 0, 5}};
        tbl[7]  = '{OP_INV,   4, MS, 2, 0, '{R_HIT,   0, 0, 1, 1, MI, 0, 0, 7}};
        tbl[8]  = '{OP_RWIM, -1, MI, 0, 0, '{R_NOHIT, 0, 0, 0, 0, MI, 0, 0, 3}};
        tbl[9]  = '{OP_WRITE,-1, MI, 0, 0, '{R_NOHIT, 0, 0, 0, 0, MI, 0, 0, 3}};
        tbl[10] = '{OP_WRITE, 6, ME, 0, 0, '{R_NOHIT, 0, 0, 0, 0, MI, 0, 1, 3}};
        tbl[11] = '{OP_INV,   1, MM, 0, 0, '{R_NOHIT, 0, 0, 0, 0, MI, 0, 1, 3}};
        tbl[12] = '{OP_READ,  2, MS, 0, 0, '{R_HIT,   0, 0, 0, 0, MS, 0, 0, 3}};

        do_reset();
        for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset while a writeback is stalled: everything must be dropped.
        begin
            logic [31:0] a = 32'hABC1_2340;
            int wbseen = 0, wrseen = 0;
            build_set(a[31:20], 5, MM);
            load_set();
            for (int c = 0; c < 20 && wbseen < 2; c++) begin
                @(negedge clk);
                snp_valid = (c == 0); snp_op = OP_READ; snp_addr = a;
                l1_ready = 1; wb_ready = 0;
                if (wb_valid) wbseen++;
                if (arr_wr_en) wrseen++;
            end
            check("rst reached wb", wbseen, 2);
            rst = 1;
            @(negedge clk);
            if (arr_wr_en) wrseen++;
            check("rst drops handshakes", {wb_valid, l1_valid, arr_wr_en}, 0);
            rst = 0; l1_ready = 0;
            exp_err = 0; exp_hit = 0; exp_hitm = 0; exp_nohit = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c == 0) check("rst ready after release", {snp_ready, proto_err}, 2'b10);
                if (arr_wr_en || wb_valid || l1_valid) wrseen++;
            end
            check("rst no write", wrseen, 0);
        end

        // Two hits, one HITM, three misses from a clean counter state.
        do_reset();
        run_vec(tbl[1], "st_hitE");
        run_vec(tbl[2], "st_hitS");
        run_vec(tbl[0], "st_hitm");
        run_vec(tbl[3], "st_miss0");
        run_vec(tbl[8], "st_miss1");
        run_vec(tbl[9], "st_miss2");
        check("stats totals", {cnt_hit, cnt_hitm, cnt_nohit},
              STATS ? {32'd2, 32'd1, 32'd3} : 96'd0);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a = $urandom;
            logic [1:0] op = 2'($urandom_range(0, 3));
            int mode = $urandom_range(0, 9);
            int l1w = $urandom_range(0, 3), wbw = $urandom_range(0, 3);
            exp_t e;
            if (i % 20 == 0) do_reset();
            for (int w = 0; w < WAYS; w++) begin
                set_tag[w] = a[31:20] ^ 12'($urandom_range(1, 4095));
                set_st[w]  = 2'($urandom);
            end
            if (mode < 7) begin
                int w1 = $urandom_range(0, WAYS - 1);
                set_tag[w1] = a[31:20];
            end else if (mode == 9) begin
                int w1 = $urandom_range(0, WAYS - 1);
                int w2 = (w1 + $urandom_range(1, WAYS - 1)) % WAYS;
                set_tag[w1] = a[31:20];
                set_tag[w2] = a[31:20];
            end
            e = model(op, a[31:20], l1w, wbw);
            run_snoop(op, a, l1w, wbw);
            compare($sformatf("rnd%0d", i), e, a);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
